// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered PC with ID-stage branch/halt resolution (optional PC_BR_CNT_EN taken counter)
module pc_unit #(
    parameter int              PC_W        = 16,
    parameter int              OFF_W       = 9,
    parameter int              INSTR_BYTES = 2,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter int              HALT_DRAIN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [3:0]       id_op,
    input  logic [PC_W-1:0]  id_pc,
    input  logic [OFF_W-1:0] id_offset,
    input  logic [2:0]       id_cond,
    input  logic [2:0]       id_flags,
    input  logic [PC_W-1:0]  id_reg_data,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             halted,
    output logic [15:0]      br_taken_cnt
);

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int CNT_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
    localparam int EXT_W = (PC_W > OFF_W + 1) ? PC_W : OFF_W + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc_q, pc_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              halted_q;
    logic              cond_ok;
    logic              live;
    logic              b_taken, br_taken, hlt_take;
    logic [EXT_W-1:0]  off_ext;
    logic [PC_W-1:0]   b_target, br_target;

    // flags are {N,V,Z}
    always_comb begin
        cond_ok = 1'b0;
        case (id_cond)
            3'b000: cond_ok = ~id_flags[0];
            3'b001: cond_ok = id_flags[0];
            3'b010: cond_ok = ~id_flags[0] & ~id_flags[2];
            3'b011: cond_ok = id_flags[2];
            3'b100: cond_ok = id_flags[0] | ~id_flags[2];
            3'b101: cond_ok = id_flags[2] | id_flags[0];
            3'b110: cond_ok = id_flags[1];
            default: cond_ok = 1'b1;
        endcase
    end

    assign live     = rst_n & (state == S_RUN) & ~stall & id_valid;
    assign b_taken  = live & (id_op == OP_B) & cond_ok;
    assign br_taken = live & (id_op == OP_BR) & cond_ok;
    assign hlt_take = live & (id_op == OP_HLT);
    assign flush    = b_taken | br_taken | hlt_take;

    // Offset is a word count: sign-extend, then scale to bytes; bits above PC_W fall away.
    assign off_ext   = EXT_W'($signed(id_offset)) << 1;
    assign b_target  = id_pc + PC_W'(INSTR_BYTES) + off_ext[PC_W-1:0];
    assign br_target = {id_reg_data[PC_W-1:1], 1'b0};

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        cnt_nx   = cnt_q;
        case (state)
            S_RUN: begin
                if (!stall) begin
                    if (b_taken) begin
                        pc_nx = b_target;
                    end else if (br_taken) begin
                        pc_nx = br_target;
                    end else if (hlt_take) begin
                        pc_nx    = id_pc;
                        cnt_nx   = CNT_W'(HALT_DRAIN - 1);
                        state_nx = S_DRAIN;
                    end else begin
                        pc_nx = pc_q + PC_W'(INSTR_BYTES);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_nx = S_HALTED;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_RUN;
            pc_q     <= RESET_VEC;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_q     <= pc_nx;
            cnt_q    <= cnt_nx;
            halted_q <= (state_nx == S_HALTED);
        end
    end

    assign pc     = pc_q;
    assign halted = halted_q;

`ifdef PC_BR_CNT_EN
    logic [15:0] br_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
        end else if ((b_taken | br_taken) && br_cnt_q != 16'hFFFF) begin
            br_cnt_q <= br_cnt_q + 16'd1;
        end
    end

    assign br_taken_cnt = br_cnt_q;
`else
    assign br_taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, id_valid;
    logic [3:0]  id_op;
    logic [15:0] id_pc, id_reg_data;
    logic [8:0]  id_offset;
    logic [2:0]  id_cond, id_flags;
    logic [15:0] pc, br_taken_cnt;
    logic        flush, halted;

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid),
        .id_op(id_op), .id_pc(id_pc), .id_offset(id_offset), .id_cond(id_cond),
        .id_flags(id_flags), .id_reg_data(id_reg_data), .pc(pc), .flush(flush),
        .halted(halted), .br_taken_cnt(br_taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        halted;
        logic        flush;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [15:0] m_pc = 16'h0;
    int          m_state = 0;   // 0 run, 1 drain, 2 halted
    int          m_cnt = 0;
    logic        m_halted = 1'b0;
    logic [15:0] m_bcnt = 16'h0;
    logic        obs_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        {n, v, z} = f;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic step(input logic r, input logic s, input logic v, input logic [3:0] op,
                        input logic [15:0] ipc, input logic [8:0] off, input logic [2:0] c,
                        input logic [2:0] f, input logic [15:0] rd);
        exp_t        e;
        logic [15:0] offx;
        logic        tk;
        rst_n = r; stall = s; id_valid = v; id_op = op; id_pc = ipc;
        id_offset = off; id_cond = c; id_flags = f; id_reg_data = rd;
        @(negedge clk);
        obs_flush = flush;
        e.flush = 1'b0;
        tk = 1'b0;
        if (!r) begin
            m_pc = 16'h0; m_state = 0; m_cnt = 0; m_halted = 1'b0; m_bcnt = 16'h0;
        end else if (m_state == 0) begin
            if (s) begin
                // hold
            end else if (v && op == 4'hC && cond_true(c, f)) begin
                offx = {{6{off[8]}}, off, 1'b0};
                m_pc = ipc + 16'd2 + offx; e.flush = 1'b1; tk = 1'b1;
            end else if (v && op == 4'hD && cond_true(c, f)) begin
                m_pc = rd & 16'hFFFE; e.flush = 1'b1; tk = 1'b1;
            end else if (v && op == 4'hF) begin
                m_pc = ipc; e.flush = 1'b1; m_state = 1; m_cnt = 3;
            end else begin
                m_pc = m_pc + 16'd2;
            end
        end else if (m_state == 1) begin
            if (m_cnt == 0) begin m_state = 2; m_halted = 1'b1; end
            else m_cnt--;
        end
`ifdef PC_BR_CNT_EN
        if (tk && m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
`else
        m_bcnt = 16'h0;
`endif
        e.pc = m_pc; e.halted = m_halted; e.cnt = m_bcnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", 32'(pc), 32'(e.pc));
        check("halted", 32'(halted), 32'(e.halted));
        check("flush", 32'(obs_flush), 32'(e.flush));
        check("br_taken_cnt", 32'(br_taken_cnt), 32'(e.cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 4'h0, 16'h0, 9'h0, 3'd0, 3'd0, 16'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 16'h0, 9'h0, 3'd0, 3'd0, 16'h0);
    endtask

    initial begin
        do_reset(2);
        idle(3);
        // B taken, then B not taken (cond 000 with Z=1)
        step(1, 0, 1, 4'hC, 16'h0190, 9'd4, 3'b111, 3'b000, 16'h0);
        step(1, 0, 1, 4'hC, 16'h0190, 9'd4, 3'b000, 3'b001, 16'h0);
        // BR with N=1 then N=0
        step(1, 0, 1, 4'hD, 16'h0100, 9'd0, 3'b011, 3'b100, 16'h0191);
        step(1, 0, 1, 4'hD, 16'h0100, 9'd0, 3'b011, 3'b000, 16'h0191);
        // stall hides a taken branch until it drops
        step(1, 1, 1, 4'hC, 16'h0200, 9'd8, 3'b111, 3'b000, 16'h0);
        step(1, 1, 1, 4'hC, 16'h0200, 9'd8, 3'b111, 3'b000, 16'h0);
        step(1, 0, 1, 4'hC, 16'h0200, 9'd8, 3'b111, 3'b000, 16'h0);
        // wrap forward from 0xFFFE, offset -1 word at 0, backward below 0
        step(1, 0, 1, 4'hD, 16'h0000, 9'd0, 3'b111, 3'b000, 16'hFFFE);
        idle(2);
        step(1, 0, 1, 4'hC, 16'h0000, 9'h1FF, 3'b111, 3'b000, 16'h0);
        step(1, 0, 1, 4'hC, 16'h0000, 9'h1FC, 3'b111, 3'b000, 16'h0);
        // every condition code against every flag combination
        for (int i = 0; i < 64; i++)
            step(1, 0, 1, 4'hC, 16'h1000, 9'd3, 3'(i >> 3), 3'(i), 16'h0);
        // random mix of ops without HLT
        for (int i = 0; i < 60; i++)
            step(1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 14)), 16'($urandom) & 16'hFFFE, 9'($urandom),
                 3'($urandom), 3'($urandom), 16'($urandom));
        // taken counter starts from reset
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 4'hC, 16'h0010, 9'd2, 3'b111, 3'b000, 16'h0);
        // halt, inputs ignored while draining and halted
        step(1, 0, 1, 4'hF, 16'h0040, 9'd0, 3'b000, 3'b000, 16'h0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 4'hC, 16'h0300, 9'd6, 3'b111, 3'b000, 16'h0);
            step(1, 0, 1, 4'hE, 16'h0302, 9'd0, 3'b111, 3'b000, 16'h0);
        end
        // reset out of HALTED, then out of DRAIN
        do_reset(1);
        idle(2);
        step(1, 0, 1, 4'hF, 16'h0080, 9'd0, 3'b000, 3'b000, 16'h0);
        idle(2);
        do_reset(1);
        idle(3);
        step(1, 1, 1, 4'hF, 16'h0090, 9'd0, 3'b000, 3'b000, 16'h0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
